// File: rtl/cs_override_pipe_pkg.sv
// Shared constants and types for the control-store override pipeline.
package cs_override_pipe_pkg;

    localparam int unsigned MODRM_MOD_LSB = 6;
    localparam int unsigned MODRM_REG_LSB = 3;
    localparam int unsigned MODRM_RM_LSB  = 0;
    localparam int unsigned MODRM_FLD_W   = 3;

    localparam logic [1:0] MOD_REG  = 2'b11;
    localparam logic [1:0] SIZE_32  = 2'b10;
    localparam logic [1:0] SIZE_16  = 2'b01;
    localparam logic [1:0] MRW_NONE = 2'b00;

    typedef struct packed {
        logic r1;
        logic r2;
        logic s1;
        logic s3;
        logic size;
    } ovr_hit_t;

    // size, imm_size, m1_rw (2 bits each), four specifiers, is_mem
    function automatic int unsigned bundle_w(int unsigned reg_w);
        return 3 * 2 + 4 * reg_w + 1;
    endfunction

endpackage

// File: rtl/cs_ovr_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; head data is presented from storage.
module cs_ovr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             pop;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign rdata_o = mem_q[rd_ptr_q];
    assign pop     = ready_i && valid_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            cnt_d = cnt_q + CntW'(push_i) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cs_override_pipe.sv
// Applies ModRM / operand-size / segment-prefix overrides and queues the bundle.
// Optional override statistics counter enabled by defining CS_OVR_STATS_EN.
module cs_override_pipe
    import cs_override_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned REG_W = 3,
    parameter int unsigned SEG_N = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_mod,
    input  logic             is_double,
    input  logic             r1_mod_ovr,
    input  logic             s3_mod_ovr,
    input  logic [1:0]       op_mod_ovr,
    input  logic [1:0]       size_in,
    input  logic [1:0]       imm_size_in,
    input  logic [1:0]       m1_rw_in,
    input  logic [REG_W-1:0] r1_in,
    input  logic [REG_W-1:0] r2_in,
    input  logic [REG_W-1:0] s1_in,
    input  logic [REG_W-1:0] s3_in,
    input  logic [7:0]       b2,
    input  logic [7:0]       b3,
    input  logic             is_size,
    input  logic             is_seg,
    input  logic [SEG_N-1:0] seg_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       size_o,
    output logic [1:0]       imm_size_o,
    output logic [1:0]       m1_rw_o,
    output logic [REG_W-1:0] r1_o,
    output logic [REG_W-1:0] r2_o,
    output logic [REG_W-1:0] s1_o,
    output logic [REG_W-1:0] s3_o,
    output logic             is_mem_o,
    output logic [CNT_W-1:0] ovr_cnt
);

    localparam int unsigned BW = bundle_w(REG_W);

    logic [7:0]       modrm;
    logic             reg_form;
    ovr_hit_t         hit;
    logic [REG_W-1:0] modrm_reg, modrm_rm, seg_idx;
    logic [1:0]       size_c, imm_size_c, m1_rw_c;
    logic [REG_W-1:0] r1_c, r2_c, s1_c, s3_c;
    logic [BW-1:0]    wdata, rdata;
    logic             full, push;

    always_comb begin
        modrm     = is_double ? b3 : b2;
        reg_form  = (modrm[MODRM_MOD_LSB +: 2] == MOD_REG);
        modrm_reg = REG_W'(modrm[MODRM_REG_LSB +: MODRM_FLD_W]);
        modrm_rm  = REG_W'(modrm[MODRM_RM_LSB +: MODRM_FLD_W]);

        // Descending scan so the lowest set bit wins.
        seg_idx = s1_in;
        for (int i = int'(SEG_N) - 1; i >= 0; i--) begin
            if (seg_sel[i]) seg_idx = REG_W'(i);
        end

        hit.size = is_size && (size_in == SIZE_32);
        hit.r1   = is_mod && reg_form && r1_mod_ovr;
        hit.s3   = is_mod && reg_form && s3_mod_ovr;
        hit.r2   = is_mod && reg_form && (|op_mod_ovr);
        hit.s1   = is_mod && is_seg && (|seg_sel);

        size_c     = hit.size ? SIZE_16 : size_in;
        imm_size_c = hit.size ? SIZE_16 : imm_size_in;
        r1_c       = hit.r1 ? modrm_reg : r1_in;
        s3_c       = hit.s3 ? modrm_reg : s3_in;
        r2_c       = hit.r2 ? modrm_rm : r2_in;
        m1_rw_c    = hit.r2 ? MRW_NONE : m1_rw_in;
        s1_c       = hit.s1 ? seg_idx : s1_in;
    end

    assign wdata    = {size_c, imm_size_c, m1_rw_c, r1_c, r2_c, s1_c, s3_c, !reg_form};
    assign in_ready = !full || out_ready;
    assign push     = in_valid && in_ready;

    cs_ovr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (wdata),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .full_o  (full),
        .rdata_o (rdata)
    );

    assign {size_o, imm_size_o, m1_rw_o, r1_o, r2_o, s1_o, s3_o, is_mem_o} = rdata;

`ifdef CS_OVR_STATS_EN
    logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

    // Flushed pushes never land in the queue, so they are not counted.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (push && !flush && (|hit) && !(&ovr_cnt_q)) begin
            ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_cs_override_pipe.sv
// Self-checking bench for cs_override_pipe: directed steps plus randomized traffic
// against a queue-based reference model.
module tb_cs_override_pipe;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0] size;
        logic [1:0] imm;
        logic [1:0] mrw;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] s1;
        logic [2:0] s3;
        logic       mem;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic        is_mod, is_double, r1_mod_ovr, s3_mod_ovr, is_size, is_seg, is_mem_o;
    logic [1:0]  op_mod_ovr, size_in, imm_size_in, m1_rw_in, size_o, imm_size_o, m1_rw_o;
    logic [2:0]  r1_in, r2_in, s1_in, s3_in, r1_o, r2_o, s1_o, s3_o;
    logic [7:0]  b2, b3;
    logic [5:0]  seg_sel;
    logic [15:0] ovr_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [15:0] exp_cnt = '0;
    exp_t        head;

    always #5 clk = ~clk;

    assign head = {size_o, imm_size_o, m1_rw_o, r1_o, r2_o, s1_o, s3_o, is_mem_o};

    cs_override_pipe #(
        .DEPTH (DEPTH),
        .REG_W (3),
        .SEG_N (6),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_mod      (is_mod),
        .is_double   (is_double),
        .r1_mod_ovr  (r1_mod_ovr),
        .s3_mod_ovr  (s3_mod_ovr),
        .op_mod_ovr  (op_mod_ovr),
        .size_in     (size_in),
        .imm_size_in (imm_size_in),
        .m1_rw_in    (m1_rw_in),
        .r1_in       (r1_in),
        .r2_in       (r2_in),
        .s1_in       (s1_in),
        .s3_in       (s3_in),
        .b2          (b2),
        .b3          (b3),
        .is_size     (is_size),
        .is_seg      (is_seg),
        .seg_sel     (seg_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .size_o      (size_o),
        .imm_size_o  (imm_size_o),
        .m1_rw_o     (m1_rw_o),
        .r1_o        (r1_o),
        .r2_o        (r2_o),
        .s1_o        (s1_o),
        .s3_o        (s3_o),
        .is_mem_o    (is_mem_o),
        .ovr_cnt     (ovr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the override rules stated directly on the current inputs.
    function automatic exp_t model(output bit fired);
        exp_t     e;
        bit [7:0] m;
        bit       regf;
        m     = is_double ? b3 : b2;
        regf  = (m[7:6] == 2'd3);
        fired = 0;
        e.size = size_in;
        e.imm  = imm_size_in;
        e.mrw  = m1_rw_in;
        e.r1   = r1_in;
        e.r2   = r2_in;
        e.s1   = s1_in;
        e.s3   = s3_in;
        e.mem  = !regf;
        if (is_size && size_in == 2'd2) begin
            e.size = 2'd1;
            e.imm  = 2'd1;
            fired  = 1;
        end
        if (is_mod && regf && r1_mod_ovr) begin
            e.r1  = m[5:3];
            fired = 1;
        end
        if (is_mod && regf && s3_mod_ovr) begin
            e.s3  = m[5:3];
            fired = 1;
        end
        if (is_mod && regf && op_mod_ovr != 0) begin
            e.r2  = m[2:0];
            e.mrw = 2'd0;
            fired = 1;
        end
        if (is_mod && is_seg && seg_sel != 0) begin
            fired = 1;
            for (int i = 0; i < 6; i++) begin
                if (seg_sel[i]) begin
                    e.s1 = 3'(i);
                    break;
                end
            end
        end
        return e;
    endfunction

    task automatic clear_inputs();
        {flush, in_valid, out_ready, is_mod, is_double, r1_mod_ovr, s3_mod_ovr} = '0;
        {is_size, is_seg, op_mod_ovr, size_in, imm_size_in, m1_rw_in} = '0;
        {r1_in, r2_in, s1_in, s3_in, b2, b3, seg_sel} = '0;
    endtask

    task automatic rand_inputs();
        {is_mod, is_double, r1_mod_ovr, s3_mod_ovr, is_size, is_seg} = 6'($urandom);
        {op_mod_ovr, size_in, imm_size_in, m1_rw_in} = 8'($urandom);
        {r1_in, r2_in, s1_in, s3_in} = 12'($urandom);
        b2      = 8'($urandom);
        b3      = 8'($urandom);
        seg_sel = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
    endtask

    // Called at a negedge with inputs set: check, advance model, cross one edge.
    task automatic cycle();
        exp_t e;
        bit   f, rdy, push, pop;
        #1;
        rdy = (q.size() < DEPTH) || out_ready;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) chk("head", head, q[0]);
        chk("ovr_cnt", ovr_cnt, exp_cnt);
        e    = model(f);
        push = in_valid && rdy;
        pop  = (q.size() != 0) && out_ready;
        if (rst) begin
            q.delete();
            exp_cnt = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
`ifdef CS_OVR_STATS_EN
                if (f && exp_cnt != 16'hffff) exp_cnt++;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", head, 0);
        chk("rst_cnt", ovr_cnt, 0);

        // ModRM reg-form r1 override from byte 2
        in_valid = 1; out_ready = 1; is_mod = 1; r1_mod_ovr = 1; b2 = 8'hD8;
        cycle();
        clear_inputs(); out_ready = 1;
        #1;
        chk("t1_valid", out_valid, 1);
        chk("t1_r1", r1_o, 3);
        cycle();

        // memory form via byte 3: r2/m1_rw pass through
        clear_inputs();
        in_valid = 1; out_ready = 1; is_mod = 1; is_double = 1; b3 = 8'h45;
        op_mod_ovr = 2'b01; r2_in = 3'd5; m1_rw_in = 2'b01;
        cycle();
        clear_inputs(); out_ready = 1;
        #1;
        chk("t2_r2", r2_o, 5);
        chk("t2_mrw", m1_rw_o, 1);
        chk("t2_mem", is_mem_o, 1);
        cycle();

        // operand size override and pass-through
        clear_inputs();
        in_valid = 1; out_ready = 1; is_size = 1; size_in = 2'b10; imm_size_in = 2'b11;
        cycle();
        size_in = 2'b00;
        #1;
        chk("t3_size", size_o, 1);
        chk("t3_imm", imm_size_o, 1);
        cycle();
        clear_inputs(); out_ready = 1;
        #1;
        chk("t3_size_pass", size_o, 0);
        cycle();

        // segment prefix: lowest set bit, then empty select
        clear_inputs();
        in_valid = 1; out_ready = 1; is_mod = 1; is_seg = 1; seg_sel = 6'b001000; s1_in = 3'd6;
        cycle();
        seg_sel = 6'b000000;
        #1;
        chk("t4_s1_seg", s1_o, 3);
        cycle();
        clear_inputs(); out_ready = 1;
        #1;
        chk("t4_s1_none", s1_o, 6);
        cycle();

        // fill, stall, then push+pop on a full queue
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            rand_inputs(); in_valid = 1;
            cycle();
        end
        rand_inputs(); in_valid = 1;
        #1;
        chk("full_in_ready", in_ready, 0);
        cycle();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            rand_inputs(); in_valid = 1; out_ready = 1;
            cycle();
        end

        // flush with two queued entries and an incoming override bundle
        clear_inputs(); out_ready = 1;
        repeat (DEPTH + 1) cycle();
        for (int i = 0; i < 2; i++) begin
            clear_inputs(); in_valid = 1; is_size = 1; size_in = 2'b10;
            cycle();
        end
        clear_inputs(); flush = 1; in_valid = 1; is_size = 1; size_in = 2'b10;
        cycle();
        clear_inputs();
        #1;
        chk("flush_valid", out_valid, 0);
        cycle();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end

        // mid-stream reset discards contents
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            rand_inputs(); in_valid = 1; is_mod = 1; is_seg = 1; seg_sel = 6'b100000;
            cycle();
        end
        clear_inputs(); rst = 1;
        cycle();
        rst = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", head, 0);
        chk("mid_rst_cnt", ovr_cnt, 0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
